// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the par2ser_stream serialiser.
package par2ser_pkg;

  typedef enum logic {
    MsbFirst = 1'b0,
    LsbFirst = 1'b1
  } bit_order_e;

  // Width of the bit counter for a word of data_w bits, plus an optional parity bit.
  function automatic int unsigned cnt_width(input int unsigned data_w, input bit parity_en);
    int unsigned len;
    len = parity_en ? data_w + 1 : data_w;
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/par2ser_hold.sv
// One-word hold register with full flag; filled by load_i, emptied by drain_i.
module par2ser_hold #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      full_q <= load_i | (full_q & ~drain_i);
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with valid/ready input and one-word buffering.
// Define PAR2SER_PARITY_EN to append an even-parity bit after each word.
module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              par_valid_i,
  output logic              par_ready_o,
  input  logic [DATA_W-1:0] parallel_i,
  output logic              serial_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              parity_o,
  output logic              empty_o
);

`ifdef PAR2SER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned WordLen = DATA_W + (ParityEn ? 1 : 0);
  localparam int unsigned CntW    = cnt_width(DATA_W, ParityEn);
  localparam logic [CntW-1:0] CntLast = CntW'(WordLen - 1);
  localparam bit_order_e Order = (LSB_FIRST != 0) ? LsbFirst : MsbFirst;

  logic [DATA_W-1:0] shift_q, shift_next, next_word, hold_data;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              hold_full, at_last, accept, load_direct, hold_load, hold_drain;
  logic              data_bit;

  always_comb begin
    at_last     = busy_q && (cnt_q == CntLast);
    accept      = par_valid_i && !hold_full;
    // A word arriving on the last bit goes straight into the shifter: no bubble.
    load_direct = accept && (!busy_q || at_last);
    hold_load   = accept && busy_q && !at_last;
    hold_drain  = at_last && hold_full;
    next_word   = hold_drain ? hold_data : parallel_i;
    if (Order == LsbFirst) begin
      data_bit   = shift_q[0];
      shift_next = {1'b0, shift_q[DATA_W-1:1]};
    end else begin
      data_bit   = shift_q[DATA_W-1];
      shift_next = {shift_q[DATA_W-2:0], 1'b0};
    end
  end

  par2ser_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .data_i  (parallel_i),
    .full_o  (hold_full),
    .data_o  (hold_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (load_direct || hold_drain) begin
      shift_q <= next_word;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (at_last) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      shift_q <= shift_next;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

`ifdef PAR2SER_PARITY_EN
  logic parity_q;
  logic on_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (load_direct || hold_drain) begin
      parity_q <= ^next_word;
    end
  end

  assign on_parity = busy_q && (cnt_q == CntW'(DATA_W));
  assign serial_o  = busy_q && (on_parity ? parity_q : data_bit);
  assign parity_o  = on_parity;
`else
  assign serial_o = busy_q && data_bit;
  assign parity_o = 1'b0;
`endif

  assign valid_o     = busy_q;
  assign last_o      = at_last;
  assign par_ready_o = !hold_full;
  assign empty_o     = !busy_q && !hold_full;

endmodule

// File: tb/tb_par2ser_stream.sv
// Self-checking bench for par2ser_stream: directed vectors plus a queue-based reference model.
module tb_par2ser_stream;

  localparam int DW = 4;
`ifdef PAR2SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WL = DW + PAR;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          v0 = 1'b0, v1 = 1'b0;
  logic [DW-1:0] p0 = '0, p1 = '0;
  logic          r0, s0, val0, l0, par0, e0;
  logic          r1, s1, val1, l1, par1, e1;

  par2ser_stream #(.DATA_W(DW), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .par_valid_i(v0), .par_ready_o(r0), .parallel_i(p0),
    .serial_o(s0), .valid_o(val0), .last_o(l0), .parity_o(par0), .empty_o(e0)
  );

  par2ser_stream #(.DATA_W(DW), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .par_valid_i(v1), .par_ready_o(r1), .parallel_i(p1),
    .serial_o(s1), .valid_o(val1), .last_o(l1), .parity_o(par1), .empty_o(e1)
  );

  typedef struct packed {logic b; logic last; logic par;} exp_t;
  typedef struct {
    logic [DW-1:0] word;
    bit            lsb;
    logic [DW-1:0] bits;  // expected data bits in time order, first bit at [DW-1]
    bit            par;
  } vec_t;

  exp_t          q[$];
  bit            seen[$];
  logic [DW-1:0] src[$];
  vec_t          vt[7];
  int            checks = 0;
  int            failures = 0;
  int            nready_low = 0;
  bit            m_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for the MSB-first instance: a word is a list of bits that
  // plays out one per cycle; the block holds at most the current word plus one more.
  task automatic model_step(input bit acc, input logic [DW-1:0] w);
    exp_t e;
    int   sz;
    if (reset !== 1'b1) begin
      q.delete();
      m_ready = 1'b1;
      chk("rst_valid", val0, 0);
      chk("rst_empty", e0, 1);
      chk("rst_serial", s0, 0);
      chk("rst_last", l0, 0);
      return;
    end
    if (acc) begin
      for (int i = 0; i < DW; i++) begin
        e.b = w[DW-1-i];
        e.last = (PAR == 0) && (i == DW - 1);
        e.par = 1'b0;
        q.push_back(e);
      end
      if (PAR != 0) begin
        e.b = ^w;
        e.last = 1'b1;
        e.par = 1'b1;
        q.push_back(e);
      end
    end
    sz = q.size();
    m_ready = (sz <= WL);
    if (!r0) nready_low++;
    chk("m_ready", r0, m_ready);
    chk("m_empty", e0, sz == 0);
    chk("m_valid", val0, sz > 0);
    if (sz > 0) begin
      e = q.pop_front();
      chk("m_serial", s0, e.b);
      chk("m_last", l0, e.last);
      chk("m_parity", par0, e.par);
      seen.push_back(s0);
    end else begin
      chk("m_idle_serial", s0, 0);
      chk("m_idle_last", l0, 0);
      chk("m_idle_parity", par0, 0);
    end
  endtask

  task automatic tick(output bit acc);
    logic [DW-1:0] w;
    acc = v0 && m_ready && (reset === 1'b1);
    w = p0;
    @(posedge clk);
    #1;
    model_step(acc, w);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    bit   a;
    logic sv, vv, lv, pv, ev;
    v = vt[i];
    if (v.lsb) begin v1 = 1'b1; p1 = v.word; end
    else       begin v0 = 1'b1; p0 = v.word; end
    tick(a);
    v0 = 1'b0;
    v1 = 1'b0;
    for (int k = 0; k < WL; k++) begin
      sv = v.lsb ? s1 : s0;
      vv = v.lsb ? val1 : val0;
      lv = v.lsb ? l1 : l0;
      pv = v.lsb ? par1 : par0;
      chk($sformatf("vec%0d_valid_b%0d", i, k), vv, 1);
      chk($sformatf("vec%0d_serial_b%0d", i, k), sv, (k < DW) ? v.bits[DW-1-k] : v.par);
      chk($sformatf("vec%0d_last_b%0d", i, k), lv, k == WL - 1);
      chk($sformatf("vec%0d_parity_b%0d", i, k), pv, k == DW);
      tick(a);
    end
    chk($sformatf("vec%0d_valid_after", i), v.lsb ? val1 : val0, 0);
    chk($sformatf("vec%0d_empty_after", i), v.lsb ? e1 : e0, 1);
  endtask

  task automatic send_all(input int budget);
    int n;
    bit a;
    n = 0;
    while (src.size() > 0 && n < budget) begin
      v0 = 1'b1;
      p0 = src[0];
      tick(a);
      if (a) src.delete(0);
      n++;
    end
    v0 = 1'b0;
    chk("send_budget", src.size(), 0);
    n = 0;
    while (q.size() > 0 && n < budget) begin
      tick(a);
      n++;
    end
    chk("drain_budget", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit               a;
    logic [3*WL-1:0]  got, want;
    vt[0] = '{4'hA, 1'b0, 4'b1010, 1'b0};
    vt[1] = '{4'h1, 1'b1, 4'b1000, 1'b1};
    vt[2] = '{4'h8, 1'b1, 4'b0001, 1'b1};
    vt[3] = '{4'h3, 1'b0, 4'b0011, 1'b0};
    vt[4] = '{4'hC, 1'b1, 4'b0011, 1'b0};
    vt[5] = '{4'h6, 1'b0, 4'b0110, 1'b0};
    vt[6] = '{4'h7, 1'b0, 4'b0111, 1'b1};

    // Reset and release
    tick(a);
    tick(a);
    chk("rst_ready", r0, 1);
    chk("rst_parity", par0, 0);
    reset = 1'b1;
    tick(a);
    chk("rel_ready", r0, 1);
    chk("rel_empty", e0, 1);
    chk("rel_valid_lsb", val1, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Back-to-back words with valid held high
    seen.delete();
    src = '{4'h3, 4'hC, 4'h5};
    send_all(100);
    for (int i = 0; i < 3 * WL; i++) got[3*WL-1-i] = (i < seen.size()) ? seen[i] : 1'bx;
    if (PAR != 0) want = 15'b0011_0_1100_0_0101_0;
    else          want = 12'b0011_1100_0101;
    chk("b2b_len", seen.size(), 3 * WL);
    chk("b2b_bits", got, want);

    // Backpressure: ready must drop while a word is buffered
    nready_low = 0;
    src = '{4'h9, 4'h2, 4'hE};
    send_all(100);
    chk("bp_ready_low_seen", nready_low > 0, 1);

    // Asynchronous reset in the middle of a word
    v0 = 1'b1;
    p0 = 4'hF;
    tick(a);
    v0 = 1'b0;
    tick(a);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", val0, 0);
    chk("midrst_empty", e0, 1);
    chk("midrst_serial", s0, 0);
    chk("midrst_ready", r0, 1);
    tick(a);
    reset = 1'b1;
    tick(a);
    run_vec(5);
    run_vec(6);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 3) != 0);
      p0 = DW'($urandom);
      tick(a);
    end
    v0 = 1'b0;
    send_all(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
